// File: rtl/sale_terminal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sale_terminal_pkg
// Purpose  : Shared constants and types for the sale-terminal product cursor:
//            grid geometry, product ID width, button direction and
//            operating mode encodings, and the mode decode from the slide
//            switches.
// Revision : 1.0 - initial release
// ============================================================================
package sale_terminal_pkg;

    localparam int PRODUCT_COUNT = 12;
    localparam int PRODUCT_ID_W  = 4;
    localparam int GRID_ROWS     = 3;
    localparam int GRID_COLS     = 4;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        OFF,
        INTERACTIVE,
        BASKET
    } mode_t;

    // Both switches up counts as basket mode.
    function automatic mode_t decode_mode(input logic [1:0] sw);
        if (sw[1]) return BASKET;
        if (sw[0]) return INTERACTIVE;
        return OFF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grid_step.sv
`default_nettype none
// ============================================================================
// Module   : grid_step
// Purpose  : Combinational one-step cursor move over the product grid.
//            Grid mode (i_linear=0) moves by row/column; linear mode
//            (i_linear=1) walks product IDs in order, RIGHT/DOWN = +1 and
//            LEFT/UP = -1. Without i_wrap the move saturates at the edge and
//            o_at_edge flags that no step was possible.
// Ports    : i_id      current product ID
//            i_dir     requested direction (DIR_NONE = hold)
//            i_wrap    wrap around instead of saturating
//            i_linear  linear ID order instead of row/column moves
//            o_next_id resulting product ID
//            o_at_edge move was blocked by a grid/list edge
// Revision : 1.0 - initial release
// ============================================================================
module grid_step
    import sale_terminal_pkg::*;
#(
    parameter int ROWS = GRID_ROWS,
    parameter int COLS = GRID_COLS,
    parameter int ID_W = PRODUCT_ID_W
) (
    input  logic [ID_W-1:0] i_id,
    input  dir_t            i_dir,
    input  logic            i_wrap,
    input  logic            i_linear,
    output logic [ID_W-1:0] o_next_id,
    output logic            o_at_edge
);

    localparam int c_NUM = ROWS * COLS;

    int w_id;
    int w_row;
    int w_col;
    int w_next;

    always_comb begin
        w_id      = int'(i_id);
        w_row     = w_id / COLS;
        w_col     = w_id % COLS;
        w_next    = w_id;
        o_at_edge = 1'b0;
        if (i_linear) begin
            case (i_dir)
                DIR_RIGHT, DIR_DOWN: begin
                    if (w_id == c_NUM - 1) begin
                        if (i_wrap) w_next = 0;
                        else        o_at_edge = 1'b1;
                    end else begin
                        w_next = w_id + 1;
                    end
                end
                DIR_LEFT, DIR_UP: begin
                    if (w_id == 0) begin
                        if (i_wrap) w_next = c_NUM - 1;
                        else        o_at_edge = 1'b1;
                    end else begin
                        w_next = w_id - 1;
                    end
                end
                default: ;
            endcase
        end else begin
            case (i_dir)
                DIR_RIGHT: begin
                    if (w_col == COLS - 1) begin
                        if (i_wrap) w_col = 0;
                        else        o_at_edge = 1'b1;
                    end else begin
                        w_col = w_col + 1;
                    end
                end
                DIR_LEFT: begin
                    if (w_col == 0) begin
                        if (i_wrap) w_col = COLS - 1;
                        else        o_at_edge = 1'b1;
                    end else begin
                        w_col = w_col - 1;
                    end
                end
                DIR_DOWN: begin
                    if (w_row == ROWS - 1) begin
                        if (i_wrap) w_row = 0;
                        else        o_at_edge = 1'b1;
                    end else begin
                        w_row = w_row + 1;
                    end
                end
                DIR_UP: begin
                    if (w_row == 0) begin
                        if (i_wrap) w_row = ROWS - 1;
                        else        o_at_edge = 1'b1;
                    end else begin
                        w_row = w_row - 1;
                    end
                end
                default: ;
            endcase
            w_next = w_row * COLS + w_col;
        end
        o_next_id = ID_W'(w_next);
    end

endmodule
`default_nettype wire

// File: rtl/direction_to_product_id.sv
`default_nettype none
// ============================================================================
// Module   : direction_to_product_id
// Purpose  : Turns clean direction-button pulses into the selected product
//            ID. Interactive mode navigates the grid freely (1-cycle
//            latency); basket mode runs a one-probe-per-cycle search that
//            only lands on products whose BasketMask bit is set.
// Ports    : CLK, RST_n            clock, async active-low reset
//            CleanSWOut[1:0]      01 interactive, 1x basket, 00 off
//            BTN_UP/DOWN/LEFT/RIGHT one-cycle button pulses
//            BasketMask           bit i set = product i is in the basket
//            SelectedProductID    current cursor product ID
//            ValidID              cursor is selectable in the active mode
//            Busy                 basket search running, buttons dropped
//            MoveDone             one-cycle pulse when a move/search ends
// Config   : DIR2ID_WRAP_EN - when defined, grid moves and basket searches
//            wrap around; otherwise they saturate at the edges.
// Revision : 1.0 - initial release
// ============================================================================
module direction_to_product_id
    import sale_terminal_pkg::*;
#(
    parameter int ROWS       = GRID_ROWS,
    parameter int COLS       = GRID_COLS,
    parameter int SEARCH_MAX = 11
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic [1:0]              CleanSWOut,
    input  logic                    BTN_UP,
    input  logic                    BTN_DOWN,
    input  logic                    BTN_LEFT,
    input  logic                    BTN_RIGHT,
    input  logic [ROWS*COLS-1:0]    BasketMask,
    output logic [PRODUCT_ID_W-1:0] SelectedProductID,
    output logic                    ValidID,
    output logic                    Busy,
    output logic                    MoveDone
);

    localparam int         c_NUM       = ROWS * COLS;
    localparam int         c_LEFT_W    = 5;
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_SEARCH = 1'b1;
`ifdef DIR2ID_WRAP_EN
    localparam logic       c_WRAP      = 1'b1;
`else
    localparam logic       c_WRAP      = 1'b0;
`endif

    logic [0:0]              r_state;
    logic [PRODUCT_ID_W-1:0] r_id;
    logic                    r_valid;
    logic                    r_done;
    logic [PRODUCT_ID_W-1:0] r_probe;
    logic [c_LEFT_W-1:0]     r_left;    // probes still allowed, incl. current
    logic                    r_fwd;
    logic                    r_block;   // last search missed: no auto-search
    logic [c_NUM-1:0]        r_mask_q;
    mode_t                   r_prev_mode;

    logic [0:0]              w_state_nxt;
    logic [PRODUCT_ID_W-1:0] w_id_nxt;
    logic                    w_valid_nxt;
    logic                    w_done_nxt;
    logic [PRODUCT_ID_W-1:0] w_probe_nxt;
    logic [c_LEFT_W-1:0]     w_left_nxt;
    logic                    w_fwd_nxt;
    logic                    w_block_nxt;

    mode_t                   w_mode;
    logic                    w_basket;
    logic                    w_mode_chg;
    logic                    w_mask_chg;
    dir_t                    w_btn_dir;
    logic                    w_btn_ok;
    logic                    w_idle;
    logic                    w_auto;
    logic                    w_launch;
    logic                    w_launch_fwd;
    logic                    w_hit;
    logic                    w_stop;
    logic                    w_step_fwd;
    logic [PRODUCT_ID_W-1:0] w_step_src;
    dir_t                    w_step_dir;
    logic [PRODUCT_ID_W-1:0] w_step_next;
    logic                    w_step_edge;

    assign w_mode     = decode_mode(CleanSWOut);
    assign w_basket   = (w_mode == BASKET);
    assign w_mode_chg = (w_mode != r_prev_mode);
    assign w_mask_chg = (BasketMask != r_mask_q);
    assign w_idle     = (r_state == c_ST_IDLE);

    always_comb begin
        w_btn_dir = DIR_NONE;
        if      (BTN_UP)    w_btn_dir = DIR_UP;
        else if (BTN_DOWN)  w_btn_dir = DIR_DOWN;
        else if (BTN_LEFT)  w_btn_dir = DIR_LEFT;
        else if (BTN_RIGHT) w_btn_dir = DIR_RIGHT;
    end

    assign w_btn_ok     = (w_btn_dir != DIR_NONE);
    // Auto-search when the cursor's product leaves the basket; after a miss it
    // stays quiet until the mask changes, so a hopeless search never repeats.
    assign w_auto       = !w_btn_ok && !BasketMask[r_id] && (!r_block || w_mask_chg);
    assign w_launch     = w_basket && !w_mode_chg && w_idle && (w_btn_ok || w_auto);
    assign w_launch_fwd = !((w_btn_dir == DIR_UP) || (w_btn_dir == DIR_LEFT));

    // One stepper serves both modes: grid moves in interactive mode, linear
    // probe steps in basket mode (launch from the cursor, then from the probe).
    assign w_step_fwd = w_idle ? w_launch_fwd : r_fwd;
    assign w_step_src = w_idle ? r_id : r_probe;
    assign w_step_dir = w_basket ? (w_step_fwd ? DIR_RIGHT : DIR_LEFT) : w_btn_dir;

    grid_step #(
        .ROWS (ROWS),
        .COLS (COLS),
        .ID_W (PRODUCT_ID_W)
    ) u_grid_step (
        .i_id      (w_step_src),
        .i_dir     (w_step_dir),
        .i_wrap    (c_WRAP),
        .i_linear  (w_basket),
        .o_next_id (w_step_next),
        .o_at_edge (w_step_edge)
    );

    assign w_hit  = BasketMask[r_probe];
    assign w_stop = (r_left == c_LEFT_W'(1)) || w_step_edge;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_mode_chg) begin
            w_state_nxt = w_basket ? c_ST_SEARCH : c_ST_IDLE;
        end else if (!w_basket) begin
            w_state_nxt = c_ST_IDLE;
        end else if (r_state == c_ST_IDLE) begin
            if (w_launch) w_state_nxt = c_ST_SEARCH;
        end else if (w_hit || w_stop) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // ---------------- outputs / datapath ----------------
    always_comb begin
        w_id_nxt    = r_id;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        w_probe_nxt = r_probe;
        w_left_nxt  = r_left;
        w_fwd_nxt   = r_fwd;
        w_block_nxt = r_block && !w_mask_chg;
        if (w_mode_chg) begin
            // A mode change overrides any search in flight, without MoveDone.
            w_block_nxt = 1'b0;
            case (w_mode)
                INTERACTIVE: begin
                    w_id_nxt    = '0;
                    w_valid_nxt = 1'b1;
                end
                BASKET: begin
                    // Entry search probes ID 0 itself, so it may need all NUM probes.
                    w_probe_nxt = '0;
                    w_left_nxt  = c_LEFT_W'(c_NUM);
                    w_fwd_nxt   = 1'b1;
                    w_valid_nxt = 1'b0;
                end
                default: w_valid_nxt = 1'b0;
            endcase
        end else begin
            case (w_mode)
                INTERACTIVE: begin
                    w_valid_nxt = 1'b1;
                    if (w_btn_ok) begin
                        w_id_nxt   = w_step_next;
                        w_done_nxt = 1'b1;
                    end
                end
                BASKET: begin
                    if (r_state == c_ST_IDLE) begin
                        w_valid_nxt = BasketMask[r_id];
                        if (w_launch) begin
                            w_probe_nxt = w_step_next;
                            w_left_nxt  = c_LEFT_W'(SEARCH_MAX);
                            w_fwd_nxt   = w_launch_fwd;
                        end
                    end else if (w_hit) begin
                        w_id_nxt    = r_probe;
                        w_valid_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else if (w_stop) begin
                        w_valid_nxt = BasketMask[r_id];
                        w_done_nxt  = 1'b1;
                        w_block_nxt = 1'b1;
                    end else begin
                        w_probe_nxt = w_step_next;
                        w_left_nxt  = r_left - 1'b1;
                    end
                end
                default: w_valid_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_id        <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_probe     <= '0;
            r_left      <= '0;
            r_fwd       <= 1'b1;
            r_block     <= 1'b0;
            r_mask_q    <= '0;
            r_prev_mode <= OFF;
        end else begin
            r_id        <= w_id_nxt;
            r_valid     <= w_valid_nxt;
            r_done      <= w_done_nxt;
            r_probe     <= w_probe_nxt;
            r_left      <= w_left_nxt;
            r_fwd       <= w_fwd_nxt;
            r_block     <= w_block_nxt;
            r_mask_q    <= BasketMask;
            r_prev_mode <= w_mode;
        end
    end

    assign SelectedProductID = r_id;
    assign ValidID           = r_valid;
    assign Busy              = (r_state == c_ST_SEARCH);
    assign MoveDone          = r_done;

endmodule
`default_nettype wire
